// File: rtl/i2c_target_rx_if.sv
// Bus-side signals of the I2C target receiver: the two pins plus the open-drain
// pull-down enable that the pad logic turns into a low on sda.
interface i2c_target_rx_if;
   logic scl;
   logic sda;
   logic sda_oe;

   modport master (output scl, output sda, input sda_oe);
   modport slave  (input scl, input sda, output sda_oe);
endinterface

// File: rtl/i2c_target_rx.sv
// Clk-synchronous I2C target receiver: oversampled scl/sda, START/STOP detection,
// address match with ACK, and up to MAX_BYTES acknowledged write-data bytes.
module i2c_target_rx #(
   parameter int ADDR_W       = 7,
   parameter int MAX_BYTES    = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int GENERAL_CALL = 0,
   localparam int IDX_W       = $clog2(MAX_BYTES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   i2c_target_rx_if.slave    bus,
   input  logic              pronto,
   input  logic [ADDR_W-1:0] endereco_local,
   output logic [ADDR_W-1:0] endereco_recebido,
   output logic              escrita,
   output logic              operacao,
   output logic              endereco_ok,
   output logic [7:0]        dado_recebido,
   output logic              dado_valido,
   output logic [IDX_W-1:0]  byte_idx,
   output logic              stop
);
   localparam int SH_W  = (ADDR_W > 7) ? ADDR_W : 7;
   localparam int CNT_W = $clog2(SH_W + 1);

   typedef enum logic [2:0] {IDLE, ADDR, ACK_A, DATA, ACK_D, WAIT_STOP} state_t;

   state_t                 state_reg;
   logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
   logic                   scl_hist_reg, sda_hist_reg;
   logic [CNT_W-1:0]       bit_cnt_reg;
   logic [SH_W-1:0]        shift_reg;
   logic [IDX_W-1:0]       count_reg;
   logic                   ack_phase_reg;
   logic                   sda_oe_reg;

   logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall;
   logic start_evt, stop_evt, addr_match;
   logic [ADDR_W-1:0] addr_bits;
   logic [7:0]        data_byte;

   // Synchronisers idle at 1 so that leaving reset never fakes a bus edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
         scl_hist_reg <= 1'b1;
         sda_hist_reg <= 1'b1;
      end else begin
         scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], bus.scl};
         sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], bus.sda};
         scl_hist_reg <= scl_s;
         sda_hist_reg <= sda_s;
      end
   end

   assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
   assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist_reg;
   assign scl_fall  = ~scl_s & scl_hist_reg;
   assign sda_rise  = sda_s & ~sda_hist_reg;
   assign sda_fall  = ~sda_s & sda_hist_reg;
   assign start_evt = sda_fall & scl_s;
   assign stop_evt  = sda_rise & scl_s;

   // On the R/W clock the address bits are already in the shifter; sda_s is R/W.
   assign addr_bits  = shift_reg[ADDR_W-1:0];
   assign data_byte  = {shift_reg[6:0], sda_s};
   assign addr_match = (addr_bits == endereco_local) ||
                       ((GENERAL_CALL != 0) && (addr_bits == '0) && !sda_s);

   assign bus.sda_oe = sda_oe_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= IDLE;
         bit_cnt_reg       <= '0;
         shift_reg         <= '0;
         count_reg         <= '0;
         ack_phase_reg     <= 1'b0;
         sda_oe_reg        <= 1'b0;
         endereco_recebido <= '0;
         escrita           <= 1'b0;
         operacao          <= 1'b0;
         endereco_ok       <= 1'b0;
         dado_recebido     <= '0;
         dado_valido       <= 1'b0;
         byte_idx          <= '0;
         stop              <= 1'b0;
      end else begin
         dado_valido <= 1'b0;
         stop        <= 1'b0;
         if (start_evt && (state_reg != IDLE || pronto)) begin
            state_reg     <= ADDR;
            bit_cnt_reg   <= '0;
            count_reg     <= '0;
            ack_phase_reg <= 1'b0;
            sda_oe_reg    <= 1'b0;
            endereco_ok   <= 1'b0;
            operacao      <= 1'b1;
         end else if (stop_evt) begin
            stop        <= 1'b1;
            state_reg   <= IDLE;
            sda_oe_reg  <= 1'b0;
            operacao    <= 1'b0;
            endereco_ok <= 1'b0;
         end else begin
            case (state_reg)
               ADDR: if (scl_rise) begin
                  if (bit_cnt_reg == CNT_W'(ADDR_W)) begin
                     endereco_recebido <= addr_bits;
                     escrita           <= ~sda_s;
                     bit_cnt_reg       <= '0;
                     ack_phase_reg     <= 1'b0;
                     if (addr_match) begin
                        endereco_ok <= 1'b1;
                        state_reg   <= ACK_A;
                     end else begin
                        state_reg   <= WAIT_STOP;
                     end
                  end else begin
                     shift_reg   <= {shift_reg[SH_W-2:0], sda_s};
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
               // First fall after the frame opens the ACK window, the second closes it.
               ACK_A, ACK_D: if (scl_fall) begin
                  if (!ack_phase_reg) begin
                     sda_oe_reg    <= 1'b1;
                     ack_phase_reg <= 1'b1;
                  end else begin
                     sda_oe_reg    <= 1'b0;
                     ack_phase_reg <= 1'b0;
                     bit_cnt_reg   <= '0;
                     if (state_reg == ACK_D) begin
                        count_reg <= count_reg + 1'b1;
                        state_reg <= DATA;
                     end else begin
                        state_reg <= escrita ? DATA : WAIT_STOP;
                     end
                  end
               end
               DATA: if (scl_rise) begin
                  if (bit_cnt_reg == CNT_W'(7)) begin
                     bit_cnt_reg   <= '0;
                     ack_phase_reg <= 1'b0;
                     if (count_reg < IDX_W'(MAX_BYTES)) begin
                        dado_recebido <= data_byte;
                        dado_valido   <= 1'b1;
                        byte_idx      <= count_reg;
                        state_reg     <= ACK_D;
                     end else begin
                        state_reg     <= WAIT_STOP;
                     end
                  end else begin
                     shift_reg   <= {shift_reg[SH_W-2:0], sda_s};
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
               WAIT_STOP: sda_oe_reg <= 1'b0;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master, open-drain line model and an
// expectation model built from transaction-level rules (match, ACK, byte limits).
module tb_i2c_target_rx;
   localparam int ADDR_W    = 7;
   localparam int MAX_BYTES = 4;
   localparam int IDX_W     = $clog2(MAX_BYTES + 1);
   localparam int Q         = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, pronto, scl_drv, sda_drv;
   logic [ADDR_W-1:0] endereco_local;

   i2c_target_rx_if bus ();
   i2c_target_rx_if bus_gc ();
   assign bus.scl    = scl_drv;
   assign bus.sda    = sda_drv & ~bus.sda_oe;
   assign bus_gc.scl = scl_drv;
   assign bus_gc.sda = sda_drv & ~bus_gc.sda_oe;

   logic [ADDR_W-1:0] endereco_recebido, endereco_recebido_gc;
   logic escrita, operacao, endereco_ok, dado_valido, stop;
   logic escrita_gc, operacao_gc, endereco_ok_gc, dado_valido_gc, stop_gc;
   logic [7:0] dado_recebido, dado_recebido_gc;
   logic [IDX_W-1:0] byte_idx, byte_idx_gc;

   i2c_target_rx #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES), .SYNC_STAGES(2), .GENERAL_CALL(0)) dut (
      .clk(clk), .reset(reset), .bus(bus), .pronto(pronto), .endereco_local(endereco_local),
      .endereco_recebido(endereco_recebido), .escrita(escrita), .operacao(operacao),
      .endereco_ok(endereco_ok), .dado_recebido(dado_recebido), .dado_valido(dado_valido),
      .byte_idx(byte_idx), .stop(stop));

   i2c_target_rx #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES), .SYNC_STAGES(2), .GENERAL_CALL(1)) dut_gc (
      .clk(clk), .reset(reset), .bus(bus_gc), .pronto(pronto), .endereco_local(endereco_local),
      .endereco_recebido(endereco_recebido_gc), .escrita(escrita_gc), .operacao(operacao_gc),
      .endereco_ok(endereco_ok_gc), .dado_recebido(dado_recebido_gc), .dado_valido(dado_valido_gc),
      .byte_idx(byte_idx_gc), .stop(stop_gc));

   int checks = 0;
   int errors = 0;
   int stop_cnt = 0;
   int oe_cnt = 0;
   logic [7:0] got_data[$];
   logic [IDX_W-1:0] got_idx[$];
   logic [7:0] tx_q[$];
   bit last_gc_ack;

   always @(negedge clk) begin
      if (dado_valido) begin
         got_data.push_back(dado_recebido);
         got_idx.push_back(byte_idx);
      end
      if (stop) stop_cnt++;
      if (bus.sda_oe) oe_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_match(input logic [ADDR_W-1:0] a, input bit rw,
                                      input logic [ADDR_W-1:0] own, input bit gc);
      return (a == own) || (gc && a == '0 && !rw);
   endfunction

   task automatic wait_q();
      repeat (Q) @(posedge clk);
   endtask

   // Works both from an idle bus and as a repeated START with scl low.
   task automatic i2c_start();
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b1; wait_q();
      wait_q();
   endtask

   task automatic send_bit(input bit b);
      sda_drv = b;    wait_q();
      scl_drv = 1'b1; wait_q(); wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic ack_slot(output bit a0, output bit a1);
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      @(negedge clk);
      a0 = !bus.sda;
      a1 = !bus_gc.sda;
      wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic send_frame(input logic [7:0] b, output bit a0, output bit a1);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      ack_slot(a0, a1);
   endtask

   task automatic run_txn(input logic [ADDR_W-1:0] addr, input bit rw, input bit do_stop);
      int p0, s0, o0, nexp;
      bit a0, a1, m;
      p0 = got_data.size();
      s0 = stop_cnt;
      o0 = oe_cnt;
      m = model_match(addr, rw, endereco_local, 1'b0);
      i2c_start();
      send_frame({addr, rw}, a0, a1);
      last_gc_ack = a1;
      @(negedge clk);
      chk("addr_ack", a0, m);
      chk("addr_rx", endereco_recebido, addr);
      chk("escrita", escrita, !rw);
      foreach (tx_q[i]) begin
         send_frame(tx_q[i], a0, a1);
         chk("data_ack", a0, m && !rw && i < MAX_BYTES);
      end
      @(negedge clk);
      chk("operacao_busy", operacao, 1);
      chk("addr_ok", endereco_ok, m);
      nexp = (m && !rw) ? ((tx_q.size() < MAX_BYTES) ? tx_q.size() : MAX_BYTES) : 0;
      chk("n_valid", got_data.size() - p0, nexp);
      for (int i = 0; i < nexp && p0 + i < got_data.size(); i++) begin
         chk("data_val", got_data[p0+i], tx_q[i]);
         chk("data_idx", got_idx[p0+i], i);
      end
      if (!m) chk("oe_quiet", oe_cnt - o0, 0);
      if (do_stop) begin
         i2c_stop();
         @(negedge clk);
         chk("operacao_end", operacao, 0);
         chk("addr_ok_end", endereco_ok, 0);
      end
      chk("stop_pulses", stop_cnt - s0, do_stop);
      $display("txn addr=%02h rw=%0d bytes=%0d stop=%0d match=%0d", addr, rw, tx_q.size(), do_stop, m);
   endtask

   initial begin
      bit a0, a1;
      int s0, n;
      logic [ADDR_W-1:0] ra;
      bit rrw;
      reset = 1'b1; pronto = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1; endereco_local = 7'h5A;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {bus.sda_oe, endereco_recebido, escrita, operacao, endereco_ok,
                         dado_recebido, dado_valido, byte_idx, stop}, 0);
      reset = 1'b0; pronto = 1'b1;
      wait_q();

      tx_q = '{8'h11, 8'h22};
      run_txn(7'h5A, 1'b0, 1'b1);

      tx_q.delete();
      repeat (2) tx_q.push_back(8'($urandom));
      run_txn(7'h3C, 1'b0, 1'b1);

      tx_q.delete();
      repeat (5) tx_q.push_back(8'($urandom));
      run_txn(7'h5A, 1'b0, 1'b1);

      tx_q = '{8'hAA};
      run_txn(7'h5A, 1'b0, 1'b0);
      tx_q.delete();
      run_txn(7'h5A, 1'b1, 1'b1);

      // START while disabled: no transaction, the later STOP still pulses.
      pronto = 1'b0;
      s0 = stop_cnt;
      i2c_start();
      @(negedge clk);
      chk("pronto0_op", operacao, 0);
      send_frame({7'h5A, 1'b0}, a0, a1);
      chk("pronto0_ack", a0, 0);
      i2c_stop();
      @(negedge clk);
      chk("pronto0_stop", stop_cnt - s0, 1);
      $display("txn pronto=0 start ignored");
      pronto = 1'b1;

      tx_q = '{8'($urandom)};
      run_txn(7'h00, 1'b0, 1'b1);
      chk("gc_ack", last_gc_ack, model_match(7'h00, 1'b0, endereco_local, 1'b1));

      // Reset in the middle of a data ACK window.
      i2c_start();
      send_frame({7'h5A, 1'b0}, a0, a1);
      for (int i = 7; i >= 0; i--) send_bit(1'b0);
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      @(negedge clk);
      chk("ackd_oe", bus.sda_oe, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_reset_oe", bus.sda_oe, 0);
      chk("mid_reset_outs", {endereco_recebido, escrita, operacao, endereco_ok,
                             dado_recebido, dado_valido, byte_idx, stop}, 0);
      reset = 1'b0;
      wait_q();
      scl_drv = 1'b0; wait_q();
      i2c_stop();
      $display("txn reset during ACK_D");
      tx_q.delete();
      repeat (3) tx_q.push_back(8'($urandom));
      run_txn(7'h5A, 1'b0, 1'b1);

      for (int k = 0; k < 4; k++) begin
         ra  = ($urandom_range(0, 1) == 1) ? 7'h5A : 7'($urandom);
         rrw = ($urandom_range(0, 3) == 0);
         n   = $urandom_range(0, 6);
         tx_q.delete();
         repeat (n) tx_q.push_back(8'($urandom));
         run_txn(ra, rrw, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
